cpu_branch_pred_queue: RTL and testbench
========================================

// Module: cpu_branch_pred_queue
// PURPOSE
//   Sits after the fetch-stage branch predictor, in the feedback path back into it.
//   Fetch pushes one entry per predicted branch: PC and predicted next PC.
//   Execute resolves branches strictly in program order, oldest first.
//   The block emits a registered predictor training pulse (update/update_addr/update_taken).
//   On a wrong next-PC it also emits a mispredict/redirect and discards all younger entries.
// PARAMETERS
//   XLEN         32  address/data width
//   DEPTH_WIDTH  2   log2 of queue depth (DEPTH = 2**DEPTH_WIDTH = 4 entries)
// PORTS
//   clk            in   1            clock; all state updates on posedge
//   rst            in   1            reset, asynchronous, active-high
//   push           in   1            fetch records a predicted branch this cycle
//   push_pc        in   XLEN         PC of the branch instruction
//   push_next_pc   in   XLEN         predicted next PC (target if predicted taken, else PC+4)
//   push_taken     in   1            predictor's taken bit for this branch
//   full           out  1            DEPTH entries held; fetch must stall and not push
//   empty          out  1            no entries held
//   count          out  DEPTH_WIDTH+1  entries currently held
//   resolve        in   1            execute resolves the oldest entry this cycle
//   resolve_taken  in   1            actual branch direction
//   resolve_target in   XLEN         actual taken target (ignored when not taken)
//   flush          in   1            external flush (trap/exception): discard all entries
//   update         out  1            one-cycle training pulse toward the predictor
//   update_addr    out  XLEN         PC of the resolved branch
//   update_taken   out  1            actual direction of the resolved branch
//   mispredict     out  1            one-cycle pulse: predicted next PC was wrong
//   redirect_pc    out  XLEN         correct next PC; valid while mispredict=1
// BEHAVIOUR
//   Reset (async): pointers and count cleared.
//     Outputs after reset: empty=1, full=0, count=0, update=0, mispredict=0.
//     Outputs after reset: update_addr=0, update_taken=0, redirect_pc=0.
//     Entry storage is not reset.
//   Storage: circular buffer; wr_ptr/rd_ptr are DEPTH_WIDTH bits and wrap naturally.
//     count is the authoritative occupancy.
//     full = (count == DEPTH); empty = (count == 0); both decoded from registered count.
//   Push accepted iff push && !full. Push while full is dropped: no state change, no error.
//   Resolve accepted iff resolve && !empty. Resolve while empty is ignored: no outputs.
//   On accepted resolve of head entry H:
//     actual_next = resolve_taken ? resolve_target : H.pc + 4 (XLEN-bit add, wraps mod 2**XLEN).
//     miss = (actual_next != H.next_pc).
//   Next-cycle outputs (latency 1, registered):
//     update=1, update_addr=H.pc, update_taken=resolve_taken.
//     mispredict=miss, redirect_pc=actual_next when miss (otherwise holds last value).
//     update/mispredict are 0 in any cycle not following an accepted resolve.
//   Entry effects of an accepted resolve:
//     miss=0: head popped (rd_ptr+1, count-1).
//     miss=1: queue emptied (rd_ptr=wr_ptr, count=0); all younger entries are wrong-path.
//   Simultaneous push + resolve, miss=0: both take effect, count unchanged.
//     Push is accepted when full in this case? NO: push gated by registered full, not by the same-cycle pop.
//   Simultaneous push + resolve, miss=1: push discarded (wrong path), queue empty next cycle.
//   flush=1: queue emptied next cycle; same-cycle push discarded.
//     A same-cycle accepted resolve still produces update (training), but mispredict is forced to 0.
//     Redirect in that case is owned by the flush source.
//   push_taken is stored for debug only; mispredict is decided on next PC, not on direction.
//   A taken-predicted branch with the wrong target counts as a miss.
// TESTING
//   T1 reset mid-run: 3 entries held, assert rst asynchronously -> count=0, empty=1, no update/mispredict pulse.
//   T2 correct prediction: push pc=0x100,next=0x104; resolve taken=0 -> next cycle update=1,addr=0x100,taken=0,mispredict=0,empty=1.
//   T3 target mispredict: push pc=0x200,next=0x300, push pc=0x300,next=0x304; resolve taken=1,target=0x280
//      -> update=1,addr=0x200,mispredict=1,redirect_pc=0x280; count=0 next cycle (0x300 entry dropped).
//   T4 full/wrap: push 4 entries -> full=1; 5th push dropped; resolve all 4 correctly.
//      -> 4 update pulses in order, empty=1; push 4 more, verify ptr wrap and order preserved.
//   T5 simultaneous: count=2, push+resolve (correct) same cycle -> count stays 2.
//      Repeat with a miss -> count=0, pushed entry absent.
//   T6 flush+resolve same cycle on head pc=0x400 -> update=1,addr=0x400, mispredict=0, count=0; resolve on empty -> no pulse.

Source files
------------

// File: rtl/cpu_branch_pred_queue.sv
// Branch prediction queue between fetch and execute: holds predicted branches in
// program order, trains the predictor on resolution and redirects fetch on a wrong next PC.
module cpu_branch_pred_queue #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [XLEN-1:0]        i_push_pc,
    input  logic [XLEN-1:0]        i_push_next_pc,
    input  logic                   i_push_taken,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [DEPTH_WIDTH:0]   o_count,
    input  logic                   i_resolve,
    input  logic                   i_resolve_taken,
    input  logic [XLEN-1:0]        i_resolve_target,
    input  logic                   i_flush,
    output logic                   o_update,
    output logic [XLEN-1:0]        o_update_addr,
    output logic                   o_update_taken,
    output logic                   o_mispredict,
    output logic [XLEN-1:0]        o_redirect_pc
);

    localparam int DEPTH = 2 ** DEPTH_WIDTH;

    logic [XLEN-1:0]        r_pc_mem    [DEPTH];
    logic [XLEN-1:0]        r_npc_mem   [DEPTH];
    logic                   r_taken_mem [DEPTH];

    logic [DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [DEPTH_WIDTH:0]   r_count;

    logic                   r_update;
    logic [XLEN-1:0]        r_update_addr;
    logic                   r_update_taken;
    logic                   r_mispredict;
    logic [XLEN-1:0]        r_redirect_pc;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push_ok;
    logic                   w_res_ok;
    logic [XLEN-1:0]        w_head_pc;
    logic [XLEN-1:0]        w_head_npc;
    logic                   w_head_taken;
    logic                   w_unused_head_taken;
    logic [XLEN-1:0]        w_actual_next;
    logic                   w_miss;
    logic                   w_miss_eff;
    logic                   w_clear;
    logic                   w_wr_en;
    logic [DEPTH_WIDTH:0]   w_count_next;

    assign w_full  = (r_count == (DEPTH_WIDTH+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // Push is gated by the registered full flag, never by a same-cycle pop.
    assign w_push_ok = i_push && !w_full;
    assign w_res_ok  = i_resolve && !w_empty;

    assign w_head_pc    = r_pc_mem[r_rd_ptr];
    assign w_head_npc   = r_npc_mem[r_rd_ptr];
    assign w_head_taken = r_taken_mem[r_rd_ptr];
    // Predicted direction is kept for debug visibility; misses are judged on next PC.
    assign w_unused_head_taken = w_head_taken;

    assign w_actual_next = i_resolve_taken ? i_resolve_target : (w_head_pc + XLEN'(4));
    assign w_miss        = (w_actual_next != w_head_npc);

    // A flush owns the redirect, so it suppresses the mispredict but still empties the queue.
    assign w_miss_eff = w_res_ok && w_miss && !i_flush;
    assign w_clear    = i_flush || w_miss_eff;
    assign w_wr_en    = w_push_ok && !w_clear;

    always_comb begin
        w_count_next = r_count;
        if (w_wr_en) begin
            w_count_next = w_count_next + 1'b1;
        end
        if (w_res_ok) begin
            w_count_next = w_count_next - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_pc_mem[r_wr_ptr]    <= i_push_pc;
            r_npc_mem[r_wr_ptr]   <= i_push_next_pc;
            r_taken_mem[r_wr_ptr] <= i_push_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_clear) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_res_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_update       <= 1'b0;
            r_update_addr  <= '0;
            r_update_taken <= 1'b0;
            r_mispredict   <= 1'b0;
            r_redirect_pc  <= '0;
        end else begin
            r_update     <= w_res_ok;
            r_mispredict <= w_miss_eff;
            if (w_res_ok) begin
                r_update_addr  <= w_head_pc;
                r_update_taken <= i_resolve_taken;
            end
            if (w_miss_eff) begin
                r_redirect_pc <= w_actual_next;
            end
        end
    end

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_count        = r_count;
    assign o_update       = r_update;
    assign o_update_addr  = r_update_addr;
    assign o_update_taken = r_update_taken;
    assign o_mispredict   = r_mispredict;
    assign o_redirect_pc  = r_redirect_pc;

endmodule

// File: tb/tb_cpu_branch_pred_queue.sv
// Self-checking bench for cpu_branch_pred_queue: directed scenarios plus a randomized
// run, all checked against a queue-based reference model.
module tb_cpu_branch_pred_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_push;
    logic [31:0] i_push_pc;
    logic [31:0] i_push_next_pc;
    logic        i_push_taken;
    logic        o_full;
    logic        o_empty;
    logic [2:0]  o_count;
    logic        i_resolve;
    logic        i_resolve_taken;
    logic [31:0] i_resolve_target;
    logic        i_flush;
    logic        o_update;
    logic [31:0] o_update_addr;
    logic        o_update_taken;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
    } ent_t;

    ent_t        q[$];
    logic        exp_update;
    logic [31:0] exp_addr;
    logic        exp_utaken;
    logic        exp_misp;
    logic [31:0] exp_redirect;

    always #5 clk = ~clk;

    cpu_branch_pred_queue #(.XLEN(32), .DEPTH_WIDTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_push           (i_push),
        .i_push_pc        (i_push_pc),
        .i_push_next_pc   (i_push_next_pc),
        .i_push_taken     (i_push_taken),
        .o_full           (o_full),
        .o_empty          (o_empty),
        .o_count          (o_count),
        .i_resolve        (i_resolve),
        .i_resolve_taken  (i_resolve_taken),
        .i_resolve_target (i_resolve_target),
        .i_flush          (i_flush),
        .o_update         (o_update),
        .o_update_addr    (o_update_addr),
        .o_update_taken   (o_update_taken),
        .o_mispredict     (o_mispredict),
        .o_redirect_pc    (o_redirect_pc)
    );

    task automatic idle_inputs();
        i_push = 0; i_push_pc = '0; i_push_next_pc = '0; i_push_taken = 0;
        i_resolve = 0; i_resolve_taken = 0; i_resolve_target = '0; i_flush = 0;
    endtask

    task automatic model_reset();
        q.delete();
        exp_update = 0; exp_addr = '0; exp_utaken = 0; exp_misp = 0; exp_redirect = '0;
    endtask

    // Drive one cycle of stimulus, advance the reference model, and land 1ns after the edge.
    task automatic drive(input bit p, input logic [31:0] pc, input logic [31:0] npc,
                         input bit ptk, input bit r, input bit rtk,
                         input logic [31:0] tgt, input bit fl);
        ent_t        h;
        logic [31:0] act;
        bit          miss;
        bit          was_full;
        bit          res_ok;
        i_push = p; i_push_pc = pc; i_push_next_pc = npc; i_push_taken = ptk;
        i_resolve = r; i_resolve_taken = rtk; i_resolve_target = tgt; i_flush = fl;
        was_full   = (q.size() == 4);
        res_ok     = r && (q.size() != 0);
        miss       = 0;
        exp_update = res_ok;
        exp_misp   = 0;
        if (res_ok) begin
            h          = q[0];
            act        = rtk ? tgt : h.pc + 32'd4;
            miss       = (act != h.npc);
            exp_addr   = h.pc;
            exp_utaken = rtk;
            if (miss && !fl) begin
                exp_misp     = 1;
                exp_redirect = act;
            end
        end
        if (fl || (res_ok && miss)) begin
            q.delete();
        end else begin
            if (res_ok) void'(q.pop_front());
            if (p && !was_full) q.push_back('{pc, npc});
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({o_count, o_empty, o_full, o_update, o_mispredict} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_flags: count=%0d empty=%0b full=%0b upd=%0b mis=%0b, required 0 1 0 0 0",
                     o_count, o_empty, o_full, o_update, o_mispredict);
        end
        tests_run++;
        if ({o_update_addr, o_update_taken, o_redirect_pc} !== 65'd0) begin
            tests_failed++;
            $display("FAIL reset_data: addr=%h taken=%0b redir=%h, required zeros",
                     o_update_addr, o_update_taken, o_redirect_pc);
        end
        rst = 0;
        $display("[TB] reset: count=%0d empty=%0b", o_count, o_empty);
        // Mid-run: 4 pushed, 1 resolved leaves 3 held and an update pulse live.
        for (int i = 0; i < 4; i++) drive(1, 32'h40 + 32'(i*4), 32'h44 + 32'(i*4), 0, 0, 0, '0, 0);
        drive(0, '0, '0, 0, 1, 0, '0, 0);
        tests_run++;
        if (o_count !== 3'd3 || o_update !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_prep: count=%0d upd=%0b, required 3 1", o_count, o_update);
        end
        #2 rst = 1;
        #1;
        tests_run++;
        if ({o_count, o_empty, o_update, o_mispredict} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_async: count=%0d empty=%0b upd=%0b mis=%0b, required 0 1 0 0",
                     o_count, o_empty, o_update, o_mispredict);
        end
        $display("[TB] async reset mid-run: count=%0d empty=%0b upd=%0b", o_count, o_empty, o_update);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_correct();
        drive(1, 32'h100, 32'h104, 0, 0, 0, '0, 0);
        drive(0, '0, '0, 0, 1, 0, '0, 0);
        tests_run++;
        if ({o_update, o_update_addr, o_update_taken, o_mispredict, o_empty} !==
            {1'b1, 32'h100, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL correct: upd=%0b addr=%h tk=%0b mis=%0b empty=%0b, required 1 100 0 0 1",
                     o_update, o_update_addr, o_update_taken, o_mispredict, o_empty);
        end
        $display("[TB] correct: upd=%0b addr=%h mis=%0b", o_update, o_update_addr, o_mispredict);
        drive(0, '0, '0, 0, 0, 0, '0, 0);
        tests_run++;
        if (o_update !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_width: upd=%0b, required 0", o_update);
        end
    endtask

    task automatic test_target_miss();
        drive(1, 32'h200, 32'h300, 1, 0, 0, '0, 0);
        drive(1, 32'h300, 32'h304, 0, 0, 0, '0, 0);
        drive(0, '0, '0, 0, 1, 1, 32'h280, 0);
        tests_run++;
        if ({o_update, o_update_addr, o_mispredict, o_redirect_pc, o_count} !==
            {1'b1, 32'h200, 1'b1, 32'h280, 3'd0}) begin
            tests_failed++;
            $display("FAIL target_miss: upd=%0b addr=%h mis=%0b redir=%h count=%0d, required 1 200 1 280 0",
                     o_update, o_update_addr, o_mispredict, o_redirect_pc, o_count);
        end
        $display("[TB] target miss: mis=%0b redir=%h count=%0d", o_mispredict, o_redirect_pc, o_count);
        drive(0, '0, '0, 0, 1, 0, '0, 0);
        tests_run++;
        if (o_update !== 1'b0 || o_redirect_pc !== 32'h280) begin
            tests_failed++;
            $display("FAIL dropped_entry: upd=%0b redir=%h, required 0 280", o_update, o_redirect_pc);
        end
    endtask

    task automatic test_full_wrap();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++)
                drive(1, 32'h500 + 32'(pass*256 + i*16), 32'h504 + 32'(pass*256 + i*16), 0, 0, 0, '0, 0);
            tests_run++;
            if (o_full !== 1'b1 || o_count !== 3'd4) begin
                tests_failed++;
                $display("FAIL full: full=%0b count=%0d, required 1 4", o_full, o_count);
            end
            drive(1, 32'hDEAD0, 32'hDEAD4, 0, 0, 0, '0, 0);
            tests_run++;
            if (o_count !== 3'd4) begin
                tests_failed++;
                $display("FAIL push_when_full: count=%0d, required 4", o_count);
            end
            for (int i = 0; i < 4; i++) begin
                drive(0, '0, '0, 0, 1, 0, '0, 0);
                tests_run++;
                if (o_update !== 1'b1 || o_update_addr !== 32'h500 + 32'(pass*256 + i*16) || o_mispredict !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL order: upd=%0b addr=%h mis=%0b, required 1 %h 0",
                             o_update, o_update_addr, o_mispredict, 32'h500 + 32'(pass*256 + i*16));
                end
                $display("[TB] drain pass %0d: addr=%h count=%0d", pass, o_update_addr, o_count);
            end
            tests_run++;
            if (o_empty !== 1'b1) begin
                tests_failed++;
                $display("FAIL drained_empty: empty=%0b, required 1", o_empty);
            end
        end
    endtask

    task automatic test_simultaneous();
        drive(1, 32'h600, 32'h604, 0, 0, 0, '0, 0);
        drive(1, 32'h700, 32'h800, 1, 0, 0, '0, 0);
        drive(1, 32'h900, 32'h904, 0, 1, 0, '0, 0);
        tests_run++;
        if (o_count !== 3'd2 || o_update_addr !== 32'h600 || o_mispredict !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_hit: count=%0d addr=%h mis=%0b, required 2 600 0", o_count, o_update_addr, o_mispredict);
        end
        $display("[TB] simultaneous hit: count=%0d", o_count);
        // 0x700 predicted taken to 0x800 but actually falls through.
        drive(1, 32'hA00, 32'hA04, 0, 1, 0, '0, 0);
        tests_run++;
        if ({o_count, o_mispredict, o_redirect_pc} !== {3'd0, 1'b1, 32'h704}) begin
            tests_failed++;
            $display("FAIL simul_miss: count=%0d mis=%0b redir=%h, required 0 1 704", o_count, o_mispredict, o_redirect_pc);
        end
        $display("[TB] simultaneous miss: count=%0d redir=%h", o_count, o_redirect_pc);
        drive(0, '0, '0, 0, 1, 0, '0, 0);
        tests_run++;
        if (o_update !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_absent: upd=%0b, required 0", o_update);
        end
    endtask

    task automatic test_flush();
        drive(1, 32'h400, 32'h404, 0, 0, 0, '0, 0);
        drive(1, 32'h408, 32'h40C, 0, 0, 0, '0, 0);
        drive(1, 32'h50C, 32'h510, 0, 1, 1, 32'h999, 1);
        tests_run++;
        if ({o_update, o_update_addr, o_update_taken, o_mispredict, o_count, o_redirect_pc} !==
            {1'b1, 32'h400, 1'b1, 1'b0, 3'd0, 32'h704}) begin
            tests_failed++;
            $display("FAIL flush_resolve: upd=%0b addr=%h tk=%0b mis=%0b count=%0d redir=%h, required 1 400 1 0 0 704",
                     o_update, o_update_addr, o_update_taken, o_mispredict, o_count, o_redirect_pc);
        end
        $display("[TB] flush+resolve: addr=%h mis=%0b count=%0d", o_update_addr, o_mispredict, o_count);
        drive(0, '0, '0, 0, 1, 0, '0, 0);
        tests_run++;
        if (o_update !== 1'b0 || o_mispredict !== 1'b0) begin
            tests_failed++;
            $display("FAIL resolve_empty: upd=%0b mis=%0b, required 0 0", o_update, o_mispredict);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc, npc, tgt;
        bit          p, r, rtk, fl;
        for (int n = 0; n < 400; n++) begin
            pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            npc = ($urandom_range(0, 1) == 1) ? pc + 32'd4 : ($urandom() & 32'hFFFF_FFFC);
            p   = ($urandom_range(0, 99) < 60);
            r   = ($urandom_range(0, 99) < 45);
            rtk = $urandom_range(0, 1) == 1;
            fl  = ($urandom_range(0, 99) < 3);
            tgt = $urandom() & 32'hFFFF_FFFC;
            if (q.size() != 0 && $urandom_range(0, 3) != 0) begin
                // Bias toward correct predictions by aiming the outcome at the stored next PC.
                if (q[0].npc == q[0].pc + 32'd4 && $urandom_range(0, 1) == 1) rtk = 0;
                else begin rtk = 1; tgt = q[0].npc; end
            end
            drive(p, pc, npc, $urandom_range(0, 1) == 1, r, rtk, tgt, fl);
            tests_run++;
            if ({o_count, o_empty, o_full} !== {3'(q.size()), q.size() == 0, q.size() == 4}) begin
                tests_failed++;
                $display("FAIL rand_occ[%0d]: count=%0d empty=%0b full=%0b, required count %0d",
                         n, o_count, o_empty, o_full, q.size());
            end
            tests_run++;
            if ({o_update, o_mispredict} !== {exp_update, exp_misp} ||
                (exp_update && {o_update_addr, o_update_taken} !== {exp_addr, exp_utaken}) ||
                o_redirect_pc !== exp_redirect) begin
                tests_failed++;
                $display("FAIL rand_out[%0d]: upd=%0b addr=%h tk=%0b mis=%0b redir=%h, required %0b %h %0b %0b %h",
                         n, o_update, o_update_addr, o_update_taken, o_mispredict, o_redirect_pc,
                         exp_update, exp_addr, exp_utaken, exp_misp, exp_redirect);
            end
            if (n % 50 == 0)
                $display("[TB] random %0d: count=%0d upd=%0b mis=%0b", n, o_count, o_update, o_mispredict);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        #2;
        test_reset();
        test_correct();
        test_target_miss();
        test_full_wrap();
        test_simultaneous();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
